softmax_row_sched: RTL and testbench

- Row scheduler for the attention-score softmax. It accepts a frame of I_CFG_ROWS score rows (NUM words each) from the QK^T stage.
- For each row it sequences one softmax datapath instance: loads the row, holds start through the calculation, and captures the one-cycle result.
- It then presents each normalized row downstream (to the softmax·V stage) with a valid/ready handshake, row index and last flag.
- A watchdog aborts the frame if the datapath never reports valid.

---
 rtl/softmax_row_sched_if.sv | 37 +++
 rtl/softmax_row_sched.sv | 170 +++++++++++++++++
 tb/tb_softmax_row_sched.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/softmax_row_sched_if.sv
// Bundle of the row scheduler's upstream, softmax-datapath and downstream signals.
// The scheduler uses the slave view; the surrounding environment uses the master view.
interface softmax_row_sched_if #(
  parameter int D_W   = 8,
  parameter int NUM   = 16,
  parameter int ROW_W = 5
);
  logic             I_FRAME_START;
  logic [ROW_W-1:0] I_CFG_ROWS;
  logic             I_ROW_VLD;
  logic             O_ROW_RDY;
  logic [D_W-1:0]   I_ROW_DATA [0:NUM-1];
  logic             O_SM_START;
  logic [D_W-1:0]   O_SM_DATA  [0:NUM-1];
  logic             I_SM_VLD;
  logic [D_W-1:0]   I_SM_DATA  [0:NUM-1];
  logic             O_OUT_VLD;
  logic             I_OUT_RDY;
  logic [D_W-1:0]   O_OUT_DATA [0:NUM-1];
  logic [ROW_W-1:0] O_OUT_IDX;
  logic             O_OUT_LAST;
  logic             O_BUSY;
  logic             O_DONE;
  logic             O_ERR;

  modport slave (
    input  I_FRAME_START, I_CFG_ROWS, I_ROW_VLD, I_ROW_DATA, I_SM_VLD, I_SM_DATA, I_OUT_RDY,
    output O_ROW_RDY, O_SM_START, O_SM_DATA, O_OUT_VLD, O_OUT_DATA, O_OUT_IDX, O_OUT_LAST,
           O_BUSY, O_DONE, O_ERR
  );

  modport master (
    output I_FRAME_START, I_CFG_ROWS, I_ROW_VLD, I_ROW_DATA, I_SM_VLD, I_SM_DATA, I_OUT_RDY,
    input  O_ROW_RDY, O_SM_START, O_SM_DATA, O_OUT_VLD, O_OUT_DATA, O_OUT_IDX, O_OUT_LAST,
           O_BUSY, O_DONE, O_ERR
  );
endinterface

// File: rtl/softmax_row_sched.sv
// Row scheduler for attention softmax: loads each score row into one softmax datapath,
// holds start until its result returns, and hands normalized rows downstream with index/last.
module softmax_row_sched #(
  parameter int D_W      = 8,
  parameter int NUM      = 16,
  parameter int MAX_ROWS = 16,
  parameter int ROW_W    = $clog2(MAX_ROWS + 1),
  parameter int TIMEOUT  = 1023
) (
  input  logic                I_CLK,
  input  logic                I_RST_N,
  softmax_row_sched_if.slave  bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0]  WD_LIM     = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_SAT     = {WD_W{1'b1}};
  localparam logic [ROW_W-1:0] MAX_ROWS_C = ROW_W'(MAX_ROWS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_OUT  = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [ROW_W-1:0] rows_q, rows_d;
  logic [ROW_W-1:0] idx_q, idx_d;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic [D_W-1:0]   sm_data_q  [0:NUM-1];
  logic [D_W-1:0]   sm_data_d  [0:NUM-1];
  logic [D_W-1:0]   out_data_q [0:NUM-1];
  logic [D_W-1:0]   out_data_d [0:NUM-1];
  logic [ROW_W-1:0] out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             out_vld_q, out_vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // Start drops in the very cycle the result appears so the datapath cannot re-launch.
  assign bus.O_ROW_RDY  = (state_q == S_LOAD);
  assign bus.O_SM_START = (state_q == S_RUN) & ~bus.I_SM_VLD;
  assign bus.O_SM_DATA  = sm_data_q;
  assign bus.O_OUT_VLD  = out_vld_q;
  assign bus.O_OUT_DATA = out_data_q;
  assign bus.O_OUT_IDX  = out_idx_q;
  assign bus.O_OUT_LAST = out_last_q;
  assign bus.O_BUSY     = busy_q;
  assign bus.O_DONE     = done_q;
  assign bus.O_ERR      = err_q;

  // Next-state and datapath-register update logic of the row FSM
  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    idx_d      = idx_q;
    wd_d       = wd_q;
    sm_data_d  = sm_data_q;
    out_data_d = out_data_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
    out_vld_d  = out_vld_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.I_FRAME_START) begin
          if (bus.I_CFG_ROWS == {ROW_W{1'b0}}) begin
            done_d = 1'b1;
          end else begin
            rows_d  = (bus.I_CFG_ROWS > MAX_ROWS_C) ? MAX_ROWS_C : bus.I_CFG_ROWS;
            idx_d   = {ROW_W{1'b0}};
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (bus.I_ROW_VLD) begin
          sm_data_d = bus.I_ROW_DATA;
          wd_d      = {WD_W{1'b0}};
          state_d   = S_RUN;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_RUN: begin
        wd_d = (wd_q == WD_SAT) ? wd_q : wd_q + WD_W'(1);
        // A result arriving on the timeout cycle still wins.
        if (bus.I_SM_VLD) begin
          out_data_d = bus.I_SM_DATA;
          out_idx_d  = idx_q;
          out_last_d = (idx_q == rows_q - ROW_W'(1));
          out_vld_d  = 1'b1;
          state_d    = S_OUT;
        end else if (wd_q >= WD_LIM) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_OUT: begin
        if (bus.I_OUT_RDY) begin
          out_vld_d = 1'b0;
          if (out_last_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + ROW_W'(1);
            state_d = S_GAP;
          end
        end else begin
          state_d = S_OUT;
        end
      end
      S_GAP: begin
        state_d = S_LOAD;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q    <= S_IDLE;
      rows_q     <= {ROW_W{1'b0}};
      idx_q      <= {ROW_W{1'b0}};
      wd_q       <= {WD_W{1'b0}};
      out_idx_q  <= {ROW_W{1'b0}};
      out_last_q <= 1'b0;
      out_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      for (int i = 0; i < NUM; i++) begin
        sm_data_q[i]  <= {D_W{1'b0}};
        out_data_q[i] <= {D_W{1'b0}};
      end
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      idx_q      <= idx_d;
      wd_q       <= wd_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
      out_vld_q  <= out_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      sm_data_q  <= sm_data_d;
      out_data_q <= out_data_d;
    end
  end

endmodule

// File: tb/tb_softmax_row_sched.sv
// Scoreboard bench for softmax_row_sched with a latency-10 datapath stub that relaunches
// whenever it sees start high while idle; its result is the bitwise inverse of the loaded row.
module tb_softmax_row_sched;
  localparam int D_W = 8, NUM = 16, MAX_ROWS = 16, ROW_W = 5, TIMEOUT = 50, LAT = 10;
  localparam int RQ = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  softmax_row_sched_if #(.D_W(D_W), .NUM(NUM), .ROW_W(ROW_W)) bus ();

  softmax_row_sched #(.D_W(D_W), .NUM(NUM), .MAX_ROWS(MAX_ROWS), .ROW_W(ROW_W), .TIMEOUT(TIMEOUT))
    dut (.I_CLK(clk), .I_RST_N(rst_n), .bus(bus.slave));

  // scoreboard of expected output rows (written by stimulus, read by monitor)
  logic [D_W*NUM-1:0] sb_data [0:RQ-1];
  logic [ROW_W-1:0]   sb_idx  [0:RQ-1];
  logic               sb_last [0:RQ-1];
  int sb_wp = 0, sb_rp = 0;
  // sequence-level expectations posted by stimulus, compared by monitor
  string       req_name [0:RQ-1];
  logic [31:0] req_act  [0:RQ-1];
  logic [31:0] req_exp  [0:RQ-1];
  int rq_wp = 0, rq_rp = 0;

  int checks = 0, errors = 0;
  int start_rises = 0, stub_vld_total = 0, done_total = 0;
  logic stub_hang = 1'b0;
  logic stub_busy;
  int   stub_cnt;
  logic prev_start;
  logic [D_W-1:0] stub_cap [0:NUM-1];

  // datapath stub
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_busy <= 1'b0; stub_cnt <= 0; prev_start <= 1'b0; bus.I_SM_VLD <= 1'b0;
      for (int j = 0; j < NUM; j++) begin bus.I_SM_DATA[j] <= 8'h00; stub_cap[j] <= 8'h00; end
    end else begin
      bus.I_SM_VLD <= 1'b0;
      prev_start   <= bus.O_SM_START;
      if (bus.O_SM_START && !prev_start) start_rises <= start_rises + 1;
      if (stub_busy) begin
        if (!bus.O_SM_START) stub_busy <= 1'b0;
        else if (stub_cnt == LAT - 1) begin
          stub_busy <= 1'b0; bus.I_SM_VLD <= 1'b1; stub_vld_total <= stub_vld_total + 1;
          for (int j = 0; j < NUM; j++) bus.I_SM_DATA[j] <= ~stub_cap[j];
        end else stub_cnt <= stub_cnt + 1;
      end else if (bus.O_SM_START && !stub_hang) begin
        stub_busy <= 1'b1; stub_cnt <= 0;
        for (int j = 0; j < NUM; j++) stub_cap[j] <= bus.O_SM_DATA[j];
      end
    end
  end

  always @(posedge clk) if (bus.O_DONE) done_total <= done_total + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h expected %0h", name, act, exp);
    end
  endtask

  logic               held_v = 1'b0;
  logic [D_W*NUM-1:0] held_data;
  logic [ROW_W-1:0]   held_idx;
  logic               held_last;
  logic               mon_prev_start = 1'b0;
  logic [D_W*NUM-1:0] act_data, sm_pk, cap_pk;

  // monitor: drains posted expectations, checks invariants and pops scoreboard on handshake
  always @(negedge clk) begin
    while (rq_rp != rq_wp) begin
      chk(req_name[rq_rp % RQ], 128'(req_act[rq_rp % RQ]), 128'(req_exp[rq_rp % RQ]));
      rq_rp++;
    end
    for (int j = 0; j < NUM; j++) begin
      act_data[j*D_W +: D_W] = bus.O_OUT_DATA[j];
      sm_pk[j*D_W +: D_W]    = bus.O_SM_DATA[j];
      cap_pk[j*D_W +: D_W]   = stub_cap[j];
    end
    if (rst_n) begin
      if (bus.I_SM_VLD)  chk("start_low_on_vld", 128'(bus.O_SM_START), 128'(0));
      if (bus.O_ROW_RDY) chk("start_low_before_load", 128'(mon_prev_start), 128'(0));
      if (bus.O_OUT_VLD) chk("row_rdy_low_during_out", 128'(bus.O_ROW_RDY), 128'(0));
      if (stub_busy && bus.O_SM_START) chk("sm_data_stable", sm_pk, cap_pk);
      if (held_v && bus.O_OUT_VLD) begin
        chk("stall_data_stable", act_data, held_data);
        chk("stall_idx_stable", 128'(bus.O_OUT_IDX), 128'(held_idx));
        chk("stall_last_stable", 128'(bus.O_OUT_LAST), 128'(held_last));
      end
      if (bus.O_OUT_VLD && bus.I_OUT_RDY) begin
        if (sb_rp == sb_wp) chk("unexpected_output", 128'(1), 128'(0));
        else begin
          chk("out_data", act_data, sb_data[sb_rp % RQ]);
          chk("out_idx", 128'(bus.O_OUT_IDX), 128'(sb_idx[sb_rp % RQ]));
          chk("out_last", 128'(bus.O_OUT_LAST), 128'(sb_last[sb_rp % RQ]));
          sb_rp++;
        end
        held_v = 1'b0;
      end else begin
        held_v = bus.O_OUT_VLD; held_data = act_data;
        held_idx = bus.O_OUT_IDX; held_last = bus.O_OUT_LAST;
      end
    end else held_v = 1'b0;
    mon_prev_start = bus.O_SM_START;
  end

  task automatic req(input string n, input logic [31:0] a, input logic [31:0] e);
    req_name[rq_wp % RQ] = n; req_act[rq_wp % RQ] = a; req_exp[rq_wp % RQ] = e;
    rq_wp++;
  endtask

  task automatic run_frame(input int cfg, input int exp_rows, input int stall_idx,
                           input int hang_idx, input int rst_idx, input bit uniform, input int seed);
    int r_rises, r_vld, r_done, n;
    logic [D_W*NUM-1:0] exp_pk;
    logic seen_rdy;
    r_rises = start_rises; r_vld = stub_vld_total; r_done = done_total;
    @(negedge clk); bus.I_FRAME_START = 1'b1; bus.I_CFG_ROWS = cfg[ROW_W-1:0];
    @(negedge clk); bus.I_FRAME_START = 1'b0;
    if (exp_rows == 0) begin
      req("zero_done", 32'(bus.O_DONE), 32'd1);
      req("zero_busy", 32'(bus.O_BUSY), 32'd0);
      seen_rdy = 1'b0;
      repeat (5) begin @(negedge clk); if (bus.O_ROW_RDY) seen_rdy = 1'b1; end
      req("zero_no_row_rdy", 32'(seen_rdy), 32'd0);
      req("zero_done_pulses", 32'(done_total - r_done), 32'd1);
      return;
    end
    req("busy_after_start", 32'(bus.O_BUSY), 32'd1);
    req("err_cleared_on_start", 32'(bus.O_ERR), 32'd0);
    for (int r = 0; r < exp_rows; r++) begin
      n = 0;
      while (!bus.O_ROW_RDY && n < 200) begin @(negedge clk); n++; end
      if (!bus.O_ROW_RDY) begin req("row_rdy_wait_expired", 32'd0, 32'd1); return; end
      stub_hang = (r == hang_idx);
      for (int j = 0; j < NUM; j++) begin
        bus.I_ROW_DATA[j] = uniform ? 8'h10 : 8'(seed + r * 17 + j);
        exp_pk[j*D_W +: D_W] = ~bus.I_ROW_DATA[j];
      end
      bus.I_ROW_VLD = 1'b1;
      @(negedge clk); bus.I_ROW_VLD = 1'b0;
      if (r == hang_idx) begin
        n = 0;
        while (bus.O_SM_START && n < 200) begin n++; @(negedge clk); end
        req("timeout_start_cycles", 32'(n), 32'(TIMEOUT));
        req("timeout_err", 32'(bus.O_ERR), 32'd1);
        req("timeout_done", 32'(bus.O_DONE), 32'd1);
        req("timeout_busy", 32'(bus.O_BUSY), 32'd0);
        @(negedge clk);
        req("timeout_done_one_cycle", 32'(bus.O_DONE), 32'd0);
        req("timeout_no_row_rdy", 32'(bus.O_ROW_RDY), 32'd0);
        stub_hang = 1'b0;
        return;
      end
      if (r == rst_idx) begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        req("rst_sm_start", 32'(bus.O_SM_START), 32'd0);
        req("rst_busy", 32'(bus.O_BUSY), 32'd0);
        req("rst_out_vld", 32'(bus.O_OUT_VLD), 32'd0);
        req("rst_row_rdy", 32'(bus.O_ROW_RDY), 32'd0);
        req("rst_sm_data0", 32'(bus.O_SM_DATA[0]), 32'd0);
        req("rst_sm_data15", 32'(bus.O_SM_DATA[NUM-1]), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        return;
      end
      sb_data[sb_wp % RQ] = exp_pk; sb_idx[sb_wp % RQ] = ROW_W'(r);
      sb_last[sb_wp % RQ] = (r == exp_rows - 1); sb_wp++;
      if (r == stall_idx) bus.I_OUT_RDY = 1'b0;
      n = 0;
      while (!bus.O_OUT_VLD && n < 200) begin @(negedge clk); n++; end
      if (!bus.O_OUT_VLD) begin req("out_vld_wait_expired", 32'd0, 32'd1); bus.I_OUT_RDY = 1'b1; return; end
      if (r == stall_idx) begin
        repeat (20) @(negedge clk);
        req("stall_vld_held", 32'(bus.O_OUT_VLD), 32'd1);
        bus.I_OUT_RDY = 1'b1;
      end
      @(negedge clk);
      if (r == exp_rows - 1) begin
        req("end_done", 32'(bus.O_DONE), 32'd1);
        req("end_busy", 32'(bus.O_BUSY), 32'd0);
        req("end_err", 32'(bus.O_ERR), 32'd0);
        @(negedge clk);
        req("end_done_one_cycle", 32'(bus.O_DONE), 32'd0);
      end else begin
        req("gap_row_rdy_low", 32'(bus.O_ROW_RDY), 32'd0);
        @(negedge clk);
        req("load_after_gap", 32'(bus.O_ROW_RDY), 32'd1);
      end
    end
    req("start_rises", 32'(start_rises - r_rises), 32'(exp_rows));
    req("sm_vld_count", 32'(stub_vld_total - r_vld), 32'(exp_rows));
    req("done_pulses", 32'(done_total - r_done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.I_FRAME_START = 1'b0; bus.I_CFG_ROWS = 5'd0; bus.I_ROW_VLD = 1'b0; bus.I_OUT_RDY = 1'b1;
    for (int j = 0; j < NUM; j++) bus.I_ROW_DATA[j] = 8'h00;
    repeat (3) @(negedge clk);
    req("reset_busy", 32'(bus.O_BUSY), 32'd0);
    req("reset_done", 32'(bus.O_DONE), 32'd0);
    req("reset_err", 32'(bus.O_ERR), 32'd0);
    req("reset_out_vld", 32'(bus.O_OUT_VLD), 32'd0);
    req("reset_row_rdy", 32'(bus.O_ROW_RDY), 32'd0);
    req("reset_sm_start", 32'(bus.O_SM_START), 32'd0);
    req("reset_out_data0", 32'(bus.O_OUT_DATA[0]), 32'd0);
    req("reset_out_idx", 32'(bus.O_OUT_IDX), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame(3, 3, -1, -1, -1, 1'b1, 0);     // uniform rows
    run_frame(3, 3, 1, -1, -1, 1'b0, 8'h20);  // downstream stall on idx 1
    run_frame(4, 4, -1, 1, -1, 1'b0, 8'h40);  // datapath hangs on row 1
    run_frame(2, 2, -1, -1, -1, 1'b0, 8'h60); // clears sticky error
    run_frame(0, 0, -1, -1, -1, 1'b0, 0);
    run_frame(20, 16, -1, -1, -1, 1'b0, 8'h80);
    run_frame(4, 4, -1, -1, 2, 1'b0, 8'hA0);  // reset during row 2
    repeat (2) @(negedge clk);
    run_frame(2, 2, -1, -1, -1, 1'b0, 8'hC0);
    repeat (5) @(negedge clk);
    req("scoreboard_drained", 32'(sb_wp - sb_rp), 32'd0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
